// File: rtl/adder_bench_pkg.sv
// Shared widths and FSM state encoding for the adder benchmark blocks.
package adder_bench_pkg;

  localparam int ADDER_WIDTH = 81;
  localparam int SUM_WIDTH   = ADDER_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_acc_datapath.sv
// Accumulator datapath: running total, sticky carry-out flag and beat count.
// clear zeroes everything; load_beat folds one zero-extended sum into the total.
module adder_acc_datapath #(
  parameter int SUM_WIDTH   = 82,
  parameter int ACC_WIDTH   = 96,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load_beat,
  input  logic [SUM_WIDTH-1:0]   sum,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  // One extra bit on the adder captures the carry out of the accumulator.
  logic [ACC_WIDTH:0] sum_ext;
  logic [ACC_WIDTH:0] add_res;

  assign sum_ext = (ACC_WIDTH + 1)'(sum);
  assign add_res = {1'b0, acc} + sum_ext;

  // Accumulator, count and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (load_beat) begin
      acc      <= add_res[ACC_WIDTH-1:0];
      count    <= count + COUNT_WIDTH'(1);
      overflow <= overflow | add_res[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Batch accumulator for registered adder sums.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from the state register only,
// so neither depends combinationally on any input. Once out_valid is high the
// result stays stable until out_ready is seen.
module adder_sum_accumulator
  import adder_bench_pkg::*;
#(
  parameter int SUM_WIDTH   = adder_bench_pkg::SUM_WIDTH,
  parameter int ACC_WIDTH   = 96,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_items,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SUM_WIDTH-1:0]   in_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_overflow,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  if (ACC_WIDTH < SUM_WIDTH) begin : g_width_check
    $error("adder_sum_accumulator: ACC_WIDTH must be >= SUM_WIDTH");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] target;
  logic                   dp_clear;
  logic                   dp_load;
  logic                   beat;

  assign beat = in_valid & in_ready;

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    dp_clear  = 1'b0;
    dp_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dp_clear  = 1'b1;
          state_nxt = (num_items == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          dp_load = 1'b1;
          if ((out_count + COUNT_WIDTH'(1)) == target) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Batch length is captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else if (state == ST_IDLE && start) begin
      target <= num_items;
    end
  end

  adder_acc_datapath #(
    .SUM_WIDTH  (SUM_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (dp_clear),
    .load_beat(dp_load),
    .sum      (in_sum),
    .acc      (out_acc),
    .count    (out_count),
    .overflow (out_overflow)
  );

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a 96-bit accumulator instance plus an
// 82-bit instance used to reach the carry-out case.
module tb_adder_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_items;
  logic        in_valid;
  logic [81:0] in_sum;
  logic        out_ready;
  logic        sel;

  logic        in_ready_a, out_valid_a, out_overflow_a, busy_a;
  logic [95:0] out_acc_a;
  logic [7:0]  out_count_a;
  logic [1:0]  dbg_a;
  logic        in_ready_b, out_valid_b, out_overflow_b, busy_b;
  logic [81:0] out_acc_b;
  logic [7:0]  out_count_b;
  logic [1:0]  dbg_b;

  logic        cur_in_ready, cur_out_valid, cur_ovf, cur_busy;
  logic [95:0] cur_acc;
  logic [7:0]  cur_count;

  int          errors = 0;
  int          checks = 0;

  // Scoreboard: expected results queued when a batch's last beat is driven.
  logic [95:0] exp_q[$];
  logic [7:0]  exp_cnt_q[$];
  logic        exp_ovf_q[$];
  logic [95:0] m_acc;
  logic [7:0]  m_cnt;
  logic [7:0]  m_target;
  logic        m_ovf;
  int          m_width = 96;

  adder_sum_accumulator #(.SUM_WIDTH(82), .ACC_WIDTH(96), .COUNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .num_items(num_items),
    .in_valid(in_valid && !sel), .in_ready(in_ready_a), .in_sum(in_sum),
    .out_valid(out_valid_a), .out_ready(out_ready && !sel), .out_acc(out_acc_a),
    .out_count(out_count_a), .out_overflow(out_overflow_a), .busy(busy_a),
    .dbg_state(dbg_a)
  );

  adder_sum_accumulator #(.SUM_WIDTH(82), .ACC_WIDTH(82), .COUNT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .num_items(num_items),
    .in_valid(in_valid && sel), .in_ready(in_ready_b), .in_sum(in_sum),
    .out_valid(out_valid_b), .out_ready(out_ready && sel), .out_acc(out_acc_b),
    .out_count(out_count_b), .out_overflow(out_overflow_b), .busy(busy_b),
    .dbg_state(dbg_b)
  );

  assign cur_in_ready  = sel ? in_ready_b     : in_ready_a;
  assign cur_out_valid = sel ? out_valid_b    : out_valid_a;
  assign cur_ovf       = sel ? out_overflow_b : out_overflow_a;
  assign cur_busy      = sel ? busy_b         : busy_a;
  assign cur_acc       = sel ? 96'(out_acc_b) : out_acc_a;
  assign cur_count     = sel ? out_count_b    : out_count_a;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Driver: request a batch and check the one-cycle response.
  task automatic do_start(input logic [7:0] n);
    start     = 1'b1;
    num_items = n;
    cyc();
    start    = 1'b0;
    m_acc    = '0;
    m_cnt    = '0;
    m_ovf    = 1'b0;
    m_target = n;
    if (n == 8'd0) begin
      exp_q.push_back('0);
      exp_cnt_q.push_back(8'd0);
      exp_ovf_q.push_back(1'b0);
      checks++;
      if (cur_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL zero_start_valid: got %b expected 1", cur_out_valid);
      end
    end else begin
      checks++;
      if (cur_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_in_ready: got %b expected 1", cur_in_ready);
      end
    end
  endtask

  // Driver: present one beat while in ACCUM; update the model.
  task automatic beat(input logic [81:0] s);
    logic [96:0] t;
    logic [96:0] mask;
    in_valid = 1'b1;
    in_sum   = s;
    cyc();
    in_valid = 1'b0;
    mask  = (97'(1) << m_width) - 97'(1);
    t     = {1'b0, m_acc} + 97'(s);
    m_ovf = m_ovf | t[m_width];
    t     = t & mask;
    m_acc = t[95:0];
    m_cnt = m_cnt + 8'd1;
    if (m_cnt == m_target) begin
      exp_q.push_back(m_acc);
      exp_cnt_q.push_back(m_cnt);
      exp_ovf_q.push_back(m_ovf);
      checks++;
      if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL last_beat_latency: out_valid=%b in_ready=%b expected 1/0",
                 cur_out_valid, cur_in_ready);
      end
    end
  endtask

  // Scoreboard pop: wait (bounded) for a result, compare, then consume it.
  task automatic collect(input int budget);
    int          k;
    logic [95:0] e_acc;
    logic [7:0]  e_cnt;
    logic        e_ovf;
    k = 0;
    while (cur_out_valid !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    checks++;
    if (cur_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL collect_timeout: out_valid=%b after %0d cycles expected 1", cur_out_valid, k);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL collect_unexpected: got result acc=%h expected none", cur_acc);
    end else begin
      e_acc = exp_q.pop_front();
      e_cnt = exp_cnt_q.pop_front();
      e_ovf = exp_ovf_q.pop_front();
      checks++;
      if (cur_acc !== e_acc) begin
        errors++;
        $display("FAIL out_acc: got %h expected %h", cur_acc, e_acc);
      end
      checks++;
      if (cur_count !== e_cnt) begin
        errors++;
        $display("FAIL out_count: got %0d expected %0d", cur_count, e_cnt);
      end
      checks++;
      if (cur_ovf !== e_ovf) begin
        errors++;
        $display("FAIL out_overflow: got %b expected %b", cur_ovf, e_ovf);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      checks++;
      if (cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin
        errors++;
        $display("FAIL return_idle: out_valid=%b busy=%b expected 0/0", cur_out_valid, cur_busy);
      end
      checks++;
      if (cur_acc !== e_acc || cur_count !== e_cnt) begin
        errors++;
        $display("FAIL idle_hold: acc=%h count=%0d expected %h/%0d", cur_acc, cur_count, e_acc, e_cnt);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || busy_a !== 1'b0 ||
        out_acc_a !== '0 || out_count_a !== '0 || out_overflow_a !== 1'b0 ||
        dbg_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b acc=%h cnt=%0d ovf=%b st=%0d expected all 0",
               in_ready_a, out_valid_a, busy_a, out_acc_a, out_count_a, out_overflow_a, dbg_a);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    do_start(8'd3);
    beat(82'd1);
    beat(82'd2);
    beat(82'd3);
    collect(4);
  endtask

  task automatic test_backpressure();
    logic [95:0] held;
    do_start(8'd2);
    beat(82'h12345_6789abcd_ef012345);
    cyc();
    cyc();
    checks++;
    if (cur_in_ready !== 1'b1 || cur_count !== 8'd1) begin
      errors++;
      $display("FAIL gap_no_change: in_ready=%b count=%0d expected 1/1", cur_in_ready, cur_count);
    end
    beat(82'h3ffff_00000000_00000001);
    held = cur_acc;
    for (int i = 0; i < 5; i++) begin
      start     = (i == 2);
      num_items = 8'd5;
      cyc();
      start = 1'b0;
      checks++;
      if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0 || cur_acc !== held ||
          cur_count !== 8'd2) begin
        errors++;
        $display("FAIL done_hold: vld=%b rdy=%b acc=%h cnt=%0d expected 1/0/%h/2",
                 cur_out_valid, cur_in_ready, cur_acc, cur_count, held);
      end
    end
    collect(2);
    cyc();
    checks++;
    if (cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: busy=%b expected 0", cur_busy);
    end
  endtask

  task automatic test_overflow();
    sel     = 1'b1;
    m_width = 82;
    cyc();
    do_start(8'd2);
    beat({82{1'b1}});
    beat(82'd1);
    collect(3);
    sel     = 1'b0;
    m_width = 96;
    cyc();
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    in_sum   = 82'd7;
    do_start(8'd0);
    cyc();
    in_valid = 1'b0;
    collect(2);
  endtask

  task automatic test_mid_reset();
    do_start(8'd4);
    beat(82'd100);
    beat(82'd200);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_acc_a !== '0 || out_count_a !== '0 || busy_a !== 1'b0 ||
        in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: acc=%h cnt=%0d busy=%b rdy=%b vld=%b expected all 0",
               out_acc_a, out_count_a, busy_a, in_ready_a, out_valid_a);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: vld=%b busy=%b expected 0/0", out_valid_a, busy_a);
      end
    end
    rst_n = 1'b1;
    cyc();
    do_start(8'd1);
    beat(82'h5);
    collect(2);
  endtask

  task automatic test_back_to_back();
    logic [95:0] r;
    int          n;
    for (int b = 0; b < 4; b++) begin
      n = $urandom_range(1, 6);
      do_start(8'(n));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        r = {$urandom(), $urandom(), $urandom()};
        beat(r[81:0]);
      end
      collect(3);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_items = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    sel       = 1'b0;
    m_acc     = '0;
    m_cnt     = '0;
    m_ovf     = 1'b0;
    m_target  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
